// File: rtl/fft_frame_sched.sv
// rtl/fft_frame_sched.sv - frame scheduler around the fft_stageX pipeline: frame issue,
// in-flight cap, inter-frame gaps, output tagging, sequence/timeout checking and abort resync.
module fft_frame_sched #(
   parameter int TOTAL_STAGE  = 10,
   parameter int CPLX_WIDTH   = 32,
   parameter int MAX_INFLIGHT = 2,
   parameter int GAP_CYC      = 4,
   parameter int TIMEOUT      = 4096
) (
   input  logic                   iclk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic                   abort,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [CPLX_WIDTH-1:0]  s_data,
   output logic                   fft_ien,
   output logic [TOTAL_STAGE-1:0] fft_iaddr,
   output logic [CPLX_WIDTH-1:0]  fft_idata,
   input  logic                   fft_oen,
   input  logic [TOTAL_STAGE-1:0] fft_oaddr,
   input  logic [CPLX_WIDTH-1:0]  fft_odata,
   output logic                   m_valid,
   output logic [CPLX_WIDTH-1:0]  m_data,
   output logic [TOTAL_STAGE-1:0] m_index,
   output logic                   m_first,
   output logic                   m_last,
   output logic [2:0]             inflight,
   output logic                   busy,
   output logic                   seq_err,
   output logic                   tmo_err
);
   localparam logic [TOTAL_STAGE-1:0] LAST = {TOTAL_STAGE{1'b1}};
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [2:0]    MAXF     = 3'(MAX_INFLIGHT);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
   localparam logic [TW-1:0] TMO_PREV = TW'(TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GAP} state_t;

   state_t                 r_state, w_next;
   logic [TOTAL_STAGE-1:0] r_icnt, r_ocnt;
   logic [GW-1:0]          r_gap;
   logic [TW-1:0]          r_tmo;
   logic                   r_armed, r_resync;
   logic                   w_start, w_hs, w_issue_done, w_tag, w_out_done;

   // r_armed keeps s_ready low while reset is held and for the first cycle after it
   assign w_start      = enable && r_armed && (inflight < MAXF);
   assign w_hs         = s_valid && s_ready;
   assign w_issue_done = w_hs && (r_icnt == LAST);
   assign w_tag        = fft_oen && (!r_resync || (fft_oaddr == '0));
   assign w_out_done   = w_tag && (fft_oaddr == LAST);
   assign busy         = (r_state != S_IDLE) || (inflight != 3'd0);

   always_comb begin
      w_next  = r_state;
      s_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            s_ready = w_start;
            if (w_start) w_next = S_LOAD;
         end
         S_LOAD: s_ready = 1'b1;
         S_GAP:  if (r_gap == GAP_LAST) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (w_issue_done) w_next = (GAP_CYC == 0) ? S_IDLE : S_GAP;
   end

   always_ff @(posedge iclk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_gap   <= '0;
      end else begin
         r_state <= abort ? S_IDLE : w_next;
         r_gap   <= (r_state == S_GAP && !abort) ? r_gap + 1'b1 : '0;
      end
   end

   always_ff @(posedge iclk or posedge rst) begin
      if (rst) begin
         r_armed   <= 1'b0;
         r_resync  <= 1'b0;
         r_icnt    <= '0;
         r_ocnt    <= '0;
         r_tmo     <= '0;
         fft_ien   <= 1'b0;
         fft_iaddr <= '0;
         fft_idata <= '0;
         m_valid   <= 1'b0;
         m_data    <= '0;
         m_index   <= '0;
         m_first   <= 1'b0;
         m_last    <= 1'b0;
         inflight  <= 3'd0;
         seq_err   <= 1'b0;
         tmo_err   <= 1'b0;
      end else if (abort) begin
         // partial frame already in the pipeline is abandoned; outputs wait for a fresh bin 0
         r_resync <= 1'b1;
         r_icnt   <= '0;
         r_ocnt   <= '0;
         r_tmo    <= '0;
         fft_ien  <= 1'b0;
         m_valid  <= 1'b0;
         inflight <= 3'd0;
         seq_err  <= 1'b0;
         tmo_err  <= 1'b0;
      end else begin
         r_armed <= 1'b1;
         fft_ien <= w_hs;
         if (w_hs) begin
            fft_iaddr <= r_icnt;
            fft_idata <= s_data;
            r_icnt    <= r_icnt + 1'b1;
         end

         m_valid <= w_tag;
         if (w_tag) begin
            m_data  <= fft_odata;
            m_index <= fft_oaddr;
            m_first <= (fft_oaddr == '0);
            m_last  <= (fft_oaddr == LAST);
            r_ocnt  <= fft_oaddr + 1'b1;
            if (fft_oaddr != r_ocnt) seq_err <= 1'b1;
            if (fft_oaddr == '0) r_resync <= 1'b0;
         end

         if (w_issue_done && !w_out_done) begin
            inflight <= inflight + 3'd1;
         end else if (w_out_done && !w_issue_done) begin
            if (inflight == 3'd0) seq_err <= 1'b1;
            else inflight <= inflight - 3'd1;
         end

         if (w_out_done || (w_issue_done && inflight == 3'd0)) begin
            r_tmo <= '0;
         end else if (inflight != 3'd0 && r_tmo != TMO_MAX) begin
            r_tmo <= r_tmo + 1'b1;
            if (r_tmo == TMO_PREV) tmo_err <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_fft_frame_sched.sv
// tb/tb_fft_frame_sched.sv - directed bench for fft_frame_sched with N=16, GAP_CYC=2,
// MAX_INFLIGHT=2, TIMEOUT=64; the pipeline output side is driven directly by the bench.
module tb_fft_frame_sched;
   localparam int TS = 4;
   localparam int CW = 32;

   logic          iclk = 1'b0;
   logic          rst, enable, abort, s_valid, s_ready;
   logic [CW-1:0] s_data;
   logic          fft_ien, fft_oen;
   logic [TS-1:0] fft_iaddr, fft_oaddr, m_index;
   logic [CW-1:0] fft_idata, fft_odata, m_data;
   logic          m_valid, m_first, m_last, busy, seq_err, tmo_err;
   logic [2:0]    inflight;

   int errs   = 0;
   int checks = 0;
   int waits;

   logic [15:0] bubbles = 16'b0110_1001_1100_0101;

   fft_frame_sched #(
      .TOTAL_STAGE(TS), .CPLX_WIDTH(CW), .MAX_INFLIGHT(2), .GAP_CYC(2), .TIMEOUT(64)
   ) dut (
      .iclk(iclk), .rst(rst), .enable(enable), .abort(abort),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .fft_ien(fft_ien), .fft_iaddr(fft_iaddr), .fft_idata(fft_idata),
      .fft_oen(fft_oen), .fft_oaddr(fft_oaddr), .fft_odata(fft_odata),
      .m_valid(m_valid), .m_data(m_data), .m_index(m_index),
      .m_first(m_first), .m_last(m_last), .inflight(inflight),
      .busy(busy), .seq_err(seq_err), .tmo_err(tmo_err)
   );

   always #5 iclk = ~iclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge iclk);
      #1;
   endtask

   task automatic push(input logic [31:0] d, input logic [3:0] a, output int w);
      w = 0;
      s_valid = 1'b1;
      s_data  = d;
      #1;
      while (!s_ready && w < 40) begin
         step();
         w++;
      end
      chk("push_wait_bound", 32'(w < 40), 32'd1);
      step();
      s_valid = 1'b0;
      chk("fft_ien", 32'(fft_ien), 32'd1);
      chk("fft_iaddr", 32'(fft_iaddr), 32'(a));
      chk("fft_idata", fft_idata, d);
   endtask

   task automatic emit(input logic [3:0] a, input logic [31:0] d, input logic v);
      fft_oen   = 1'b1;
      fft_oaddr = a;
      fft_odata = d;
      step();
      fft_oen = 1'b0;
      chk("m_valid", 32'(m_valid), 32'(v));
      if (v) begin
         chk("m_index", 32'(m_index), 32'(a));
         chk("m_data", m_data, d);
         chk("m_first", 32'(m_first), 32'(a == 4'd0));
         chk("m_last", 32'(m_last), 32'(a == 4'd15));
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
      fft_oen = 1'b0; fft_oaddr = '0; fft_odata = '0;
      repeat (3) step();
      chk("rst_s_ready", 32'(s_ready), 0);
      chk("rst_fft_ien", 32'(fft_ien), 0);
      chk("rst_fft_iaddr", 32'(fft_iaddr), 0);
      chk("rst_fft_idata", fft_idata, 0);
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_index", 32'(m_index), 0);
      chk("rst_m_first_last", 32'({m_first, m_last}), 0);
      chk("rst_inflight", 32'(inflight), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_errs", 32'({seq_err, tmo_err}), 0);

      // reset while mid-LOAD at icnt=7
      rst = 1'b0; enable = 1'b1;
      for (int i = 0; i < 7; i++) push(32'hA000_0000 + i, 4'(i), waits);
      chk("midload_busy", 32'(busy), 1);
      rst = 1'b1;
      #1;
      chk("midrst_fft_ien", 32'(fft_ien), 0);
      chk("midrst_fft_iaddr", 32'(fft_iaddr), 0);
      chk("midrst_fft_idata", fft_idata, 0);
      chk("midrst_s_ready", 32'(s_ready), 0);
      chk("midrst_busy", 32'(busy), 0);
      step();
      rst = 1'b0;

      // 32 back-to-back samples: two frames with a 2-cycle gap
      for (int i = 0; i < 32; i++) begin
         push(32'hC000_0000 + i, 4'(i % 16), waits);
         if (i == 16) chk("gap_cycles", 32'(waits), 2);
         else if (i != 0) chk("b2b_wait", 32'(waits), 0);
      end
      chk("inflight_two", 32'(inflight), 2);
      chk("busy_two", 32'(busy), 1);

      // pipeline output held: scheduler must not start a third frame
      repeat (2) step();
      for (int i = 0; i < 4; i++) begin
         step();
         chk("hold_s_ready", 32'(s_ready), 0);
      end
      for (int i = 0; i < 16; i++) emit(4'(i), 32'hB000_0000 + i, 1'b1);
      chk("after_out_inflight", 32'(inflight), 1);
      chk("after_out_s_ready", 32'(s_ready), 1);
      for (int i = 0; i < 16; i++) emit(4'(i), 32'hB100_0000 + i, 1'b1);
      chk("frames_done_inflight", 32'(inflight), 0);
      chk("clean_seq_err", 32'(seq_err), 0);
      chk("clean_tmo_err", 32'(tmo_err), 0);

      // input bubbles produce fft_ien gaps, addresses stay contiguous
      for (int i = 0; i < 16; i++) begin
         if (bubbles[i]) begin
            s_valid = 1'b0;
            step();
            chk("bubble_ien", 32'(fft_ien), 0);
         end
         push(32'hD000_0000 + i, 4'(i), waits);
         chk("bubble_wait", 32'(waits), 0);
      end
      chk("bubble_inflight", 32'(inflight), 1);

      // output sequence 0,1,3,4..15: one error at 3, then resync
      emit(4'd0, 32'hE000_0000, 1'b1);
      emit(4'd1, 32'hE000_0001, 1'b1);
      chk("seq_before_skip", 32'(seq_err), 0);
      emit(4'd3, 32'hE000_0003, 1'b1);
      chk("seq_after_skip", 32'(seq_err), 1);
      for (int i = 4; i < 16; i++) emit(4'(i), 32'hE000_0000 + i, 1'b1);
      chk("seq_inflight", 32'(inflight), 0);

      // a frame that never comes out trips the timeout 64 cycles after issue
      for (int i = 0; i < 16; i++) push(32'hF000_0000 + i, 4'(i), waits);
      chk("tmo_inflight", 32'(inflight), 1);
      repeat (63) step();
      chk("tmo_before", 32'(tmo_err), 0);
      step();
      chk("tmo_after", 32'(tmo_err), 1);

      // abort clears state; outputs suppressed until bin 0 arrives
      enable = 1'b0;
      abort  = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_tmo_err", 32'(tmo_err), 0);
      chk("abort_seq_err", 32'(seq_err), 0);
      chk("abort_inflight", 32'(inflight), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_fft_ien", 32'(fft_ien), 0);
      emit(4'd5, 32'h1234_0005, 1'b0);
      emit(4'd6, 32'h1234_0006, 1'b0);
      emit(4'd0, 32'h1234_0000, 1'b1);
      emit(4'd1, 32'h1234_0001, 1'b1);
      chk("resync_seq_err", 32'(seq_err), 0);
      chk("resync_inflight", 32'(inflight), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
